// File: rtl/vga_frame_scheduler.sv
// Frame scheduler: round-robin update-window grants during vertical blank,
// plus fixed-priority layer colour mux with sync delay to the connector.
module vga_frame_scheduler #(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_TOTAL  = 800,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_TOTAL  = 525,
   parameter int unsigned N_REQ    = 3,
   parameter int unsigned UPD_MAX  = 1024,
   localparam int unsigned HW      = $clog2(H_TOTAL),
   localparam int unsigned VW      = $clog2(V_TOTAL)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [HW-1:0]      hcount,
   input  logic [VW-1:0]      vcount,
   input  logic               hs_in,
   input  logic               vs_in,
   input  logic [N_REQ-1:0]   req,
   output logic [N_REQ-1:0]   gnt,
   output logic [N_REQ-1:0]   overrun,
   output logic               frame_start,
   input  logic [8*N_REQ-1:0] layer_pix,
   input  logic [N_REQ-1:0]   layer_vld,
   output logic [2:0]         r,
   output logic [2:0]         g,
   output logic [1:0]         b,
   output logic               hs,
   output logic               vs
);

   localparam int unsigned LW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int unsigned CW = $clog2(UPD_MAX);

   typedef enum logic [1:0] {S_IDLE, S_ARB, S_GRANT, S_CLOSE} state_t;

   state_t           state_q, state_d;
   logic [N_REQ-1:0] gnt_q, gnt_d;
   logic [N_REQ-1:0] ovr_q, ovr_d;
   logic [LW-1:0]    last_q, last_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             fs_q, fs_d;
   logic [7:0]       pix_q, pix_d;
   logic             hs_q, vs_q;

   logic             sof;
   logic             guard;
   logic             blank_start;
   logic [LW-1:0]    pick;
   logic             pick_vld;

   assign sof         = (hcount == '0) && (vcount == '0);
   assign guard       = (vcount == VW'(V_TOTAL - 1));
   assign blank_start = (hcount == '0) && (vcount == VW'(V_ACTIVE));
   assign fs_d        = sof;

   // First requester strictly after last_q in circular order.
   always_comb begin
      logic [LW-1:0] idx;
      pick     = last_q;
      pick_vld = 1'b0;
      for (int unsigned k = 1; k <= N_REQ; k++) begin
         idx = LW'((32'(last_q) + k) % N_REQ);
         if (!pick_vld && req[idx]) begin
            pick_vld = 1'b1;
            pick     = idx;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      ovr_d   = ovr_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      if (sof) ovr_d = '0;
      unique case (state_q)
         S_IDLE: begin
            if (blank_start) state_d = S_ARB;
         end
         S_ARB: begin
            if (guard) begin
               state_d = S_CLOSE;
            end else if (pick_vld) begin
               gnt_d       = '0;
               gnt_d[pick] = 1'b1;
               last_d      = pick;
               cnt_d       = '0;
               state_d     = S_GRANT;
            end
         end
         S_GRANT: begin
            cnt_d = cnt_q + 1'b1;
            if (guard) begin
               gnt_d   = '0;
               state_d = S_CLOSE;
            end else if (!req[last_q]) begin
               gnt_d   = '0;
               state_d = S_ARB;
            end else if (cnt_q == CW'(UPD_MAX - 1)) begin
               gnt_d         = '0;
               ovr_d[last_q] = 1'b1;
               state_d       = S_ARB;
            end
         end
         S_CLOSE: begin
            if (vcount == '0) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Lowest-index opaque layer wins inside the visible area.
   always_comb begin
      logic hit;
      hit   = 1'b0;
      pix_d = '0;
      if ((hcount < HW'(H_ACTIVE)) && (vcount < VW'(V_ACTIVE))) begin
         for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!hit && layer_vld[i]) begin
               hit   = 1'b1;
               pix_d = layer_pix[8*i +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         gnt_q   <= '0;
         ovr_q   <= '0;
         last_q  <= LW'(N_REQ - 1);
         cnt_q   <= '0;
         fs_q    <= 1'b0;
         pix_q   <= '0;
         hs_q    <= 1'b1;
         vs_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         ovr_q   <= ovr_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         fs_q    <= fs_d;
         pix_q   <= pix_d;
         hs_q    <= hs_in;
         vs_q    <= vs_in;
      end
   end

   assign gnt         = gnt_q;
   assign overrun     = ovr_q;
   assign frame_start = fs_q;
   assign r           = pix_q[7:5];
   assign g           = pix_q[4:2];
   assign b           = pix_q[1:0];
   assign hs          = hs_q;
   assign vs          = vs_q;

endmodule

// File: tb/tb_vga_frame_scheduler.sv
// Scoreboard bench for vga_frame_scheduler: driver pushes model predictions,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_vga_frame_scheduler;

   localparam int N  = 3;
   localparam int HA = 640;
   localparam int HT = 800;
   localparam int VA = 480;
   localparam int VT = 525;
   localparam int UM = 1024;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [9:0]  hcount_s = '0;
   logic [9:0]  vcount_s = '0;
   logic        hs_in_s = 1'b1;
   logic        vs_in_s = 1'b1;
   logic [2:0]  req_s = '0;
   logic [23:0] pix_s = '0;
   logic [2:0]  vld_s = '0;
   logic [2:0]  gnt, overrun;
   logic        frame_start, hs, vs;
   logic [2:0]  r, g;
   logic [1:0]  b;

   always #5 clk = ~clk;

   vga_frame_scheduler #(
      .H_ACTIVE(HA), .H_TOTAL(HT), .V_ACTIVE(VA), .V_TOTAL(VT),
      .N_REQ(N), .UPD_MAX(UM)
   ) dut (
      .clk(clk), .rst(rst), .hcount(hcount_s), .vcount(vcount_s),
      .hs_in(hs_in_s), .vs_in(vs_in_s), .req(req_s), .gnt(gnt),
      .overrun(overrun), .frame_start(frame_start), .layer_pix(pix_s),
      .layer_vld(vld_s), .r(r), .g(g), .b(b), .hs(hs), .vs(vs)
   );

   typedef struct {
      int         tag;
      logic [2:0] gnt;
      logic [2:0] ovr;
      logic       fs;
      logic [7:0] pix;
      logic       hs;
      logic       vs;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference model: window open/closing flags, current holder and how long
   // it has held the grant.
   int         m_holder, m_held, m_last;
   bit         m_open, m_closing;
   logic [2:0] m_ovr;

   int         hc, vc;
   int         mode;
   logic [2:0] req_fix;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      while (q.size() > 0 && q[0].tag < cyc) begin
         e = q.pop_front();
         chk("stale_expectation", 32'(e.tag), 32'(cyc));
      end
      if (q.size() > 0 && q[0].tag == cyc) begin
         e = q.pop_front();
         chk("gnt", 32'(gnt), 32'(e.gnt));
         chk("overrun", 32'(overrun), 32'(e.ovr));
         chk("frame_start", 32'(frame_start), 32'(e.fs));
         chk("rgb", 32'({r, g, b}), 32'(e.pix));
         chk("hs", 32'(hs), 32'(e.hs));
         chk("vs", 32'(vs), 32'(e.vs));
      end
   end

   function automatic void model_reset();
      m_holder  = -1;
      m_held    = 0;
      m_last    = N - 1;
      m_open    = 1'b0;
      m_closing = 1'b0;
      m_ovr     = '0;
   endfunction

   function automatic void push_reset_exp(input int tag);
      exp_t e;
      e = '{tag: tag, gnt: 3'b000, ovr: 3'b000, fs: 1'b0, pix: 8'h00, hs: 1'b1, vs: 1'b1};
      q.push_back(e);
   endfunction

   // Predict outputs after the next clock edge from the inputs now on the bus.
   function automatic void eval_push();
      exp_t e;
      int   h, v;
      bit   sof;
      h   = int'(hcount_s);
      v   = int'(vcount_s);
      sof = (h == 0) && (v == 0);
      if (sof) m_ovr = '0;
      if (m_closing) begin
         if (v == 0) m_closing = 1'b0;
      end else if (!m_open) begin
         if (h == 0 && v == VA) m_open = 1'b1;
      end else if (m_holder < 0) begin
         if (v == VT - 1) begin
            m_open = 1'b0; m_closing = 1'b1;
         end else begin
            for (int k = 1; k <= N; k++) begin
               int i;
               i = (m_last + k) % N;
               if (req_s[i]) begin
                  m_holder = i; m_last = i; m_held = 1;
                  break;
               end
            end
         end
      end else begin
         if (v == VT - 1) begin
            m_holder = -1; m_open = 1'b0; m_closing = 1'b1;
         end else if (!req_s[m_holder]) begin
            m_holder = -1;
         end else if (m_held == UM) begin
            m_ovr[m_holder] = 1'b1;
            m_holder = -1;
         end else begin
            m_held++;
         end
      end
      e.tag = cyc + 1;
      e.gnt = (m_holder >= 0) ? 3'(1 << m_holder) : 3'b000;
      e.ovr = m_ovr;
      e.fs  = sof;
      e.pix = 8'h00;
      if (h < HA && v < VA)
         for (int i = N - 1; i >= 0; i--)
            if (vld_s[i]) e.pix = pix_s[8*i +: 8];
      e.hs = hs_in_s;
      e.vs = vs_in_s;
      q.push_back(e);
   endfunction

   task automatic apply();
      hcount_s = 10'(hc);
      vcount_s = 10'(vc);
      hs_in_s  = !(hc >= 656 && hc < 752);
      vs_in_s  = !(vc >= 490 && vc < 492);
      pix_s    = 24'($urandom);
      vld_s    = 3'($urandom);
      if (hc == 100 && vc == 50) begin
         vld_s = 3'b110;
         pix_s = {8'h1C, 8'hE0, 8'h5A};
      end
      case (mode)
         0: req_s = req_fix;
         1: for (int i = 0; i < N; i++) req_s[i] = !(m_holder == i && m_held >= 10);
         default: if ($urandom_range(7) == 0) req_s = 3'($urandom);
      endcase
   endtask

   task automatic advance();
      hc++;
      if (hc == HT) begin
         hc = 0;
         vc = (vc + 1) % VT;
      end
   endtask

   task automatic run(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         apply();
         eval_push();
         advance();
      end
   endtask

   task automatic jump(input int h, input int v);
      hc = h;
      vc = v;
   endtask

   // Asynchronous reset placed between clock edges.
   task automatic do_reset(input int n);
      #2;
      rst = 1'b0;
      q.delete();
      model_reset();
      push_reset_exp(cyc);
      repeat (n) begin
         @(posedge clk); #1;
         apply();
         push_reset_exp(cyc);
         advance();
      end
      rst = 1'b1;
      eval_push();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      errors++;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "watchdog expired");
   end

   initial begin
      model_reset();
      mode    = 2;
      req_fix = 3'b111;
      hc = 790; vc = 524;
      rst = 1'b0;
      apply();
      advance();
      repeat (3) begin
         @(posedge clk); #1;
         push_reset_exp(cyc);
         apply();
         advance();
      end
      rst = 1'b1;
      eval_push();

      // frame wrap and active video: no grants
      run(1000);
      // pixel mux and active-area boundaries
      jump(95, 50);   run(30);
      jump(630, 50);  run(200);
      jump(630, 479); run(200);
      // each requester releases after 10 grant cycles
      mode = 1;
      run(400);
      // reset in mid-window, then no grant until next blank start
      do_reset(4);
      mode = 0; req_fix = 3'b111;
      jump(0, 490);   run(100);
      jump(790, 479); run(60);
      // one requester held forever: forced revoke and re-grant
      req_fix = 3'b010;
      run(2200);
      // guard line close, then overrun cleared at frame start
      req_fix = 3'b001;
      jump(700, 523); run(200);
      jump(790, 524); run(50);
      // randomized traffic across blank start, guard line and frame wrap
      mode = 2;
      jump(700, 479); run(6000);
      jump(600, 523); run(1500);

      repeat (3) @(negedge clk);
      chk("queue_drained", 32'(q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
